// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle CPU control unit
// State codes are fixed because they are exported on the debug state port.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BEQ     = 4'd8,
    S_JMP     = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_BNE     = 4'd12,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state (+zero) to control-signal decode
// The BNE decode exists only when MC_CTRL_BNE_EN is defined.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       zero,
  output logic       pc_we,
  output logic       i_or_d,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       halted
);

  always_comb begin
    pc_we      = 1'b0;
    i_or_d     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    halted     = 1'b0;
    case (state)
      S_IF: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        alu_src_b = SRCB_ONE;
      end
      // Speculatively compute the branch target into ALUOut.
      S_ID:      alu_src_b = SRCB_BOFF;
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD:  i_or_d = 1'b1;
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d = 1'b1;
        mem_we = 1'b1;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: reg_we = 1'b1;
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_we     = zero;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_we     = ~zero;
      end
`endif
      S_JMP: begin
        pc_src = PCSRC_JUMP;
        pc_we  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle CPU main control FSM (state register + next state)
// Define MC_CTRL_BNE_EN to make opcode 000101 a legal bne instruction.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pc_we,
  output logic       i_or_d,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_mem_op(op))        state_d = S_MEM_ADR;
        else if (op == OP_RTYPE)  state_d = S_R_EX;
        else if (op == OP_BEQ)    state_d = S_BEQ;
        else if (op == OP_J)      state_d = S_JMP;
        else if (op == OP_ADDI)   state_d = S_ADDI_EX;
`ifdef MC_CTRL_BNE_EN
        else if (op == OP_BNE)    state_d = S_BNE;
`endif
        else                      state_d = S_HALT;
      end
      // The IR still holds the opcode here, so lw/sw can be split again.
      S_MEM_ADR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_R_EX:    state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IF;
    endcase
  end

  assign state = state_q;

  mc_ctrl_decode u_decode (
    .state      (state_q),
    .zero       (zero),
    .pc_we      (pc_we),
    .i_or_d     (i_or_d),
    .mem_we     (mem_we),
    .ir_we      (ir_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .halted     (halted)
  );

endmodule
